channel_select_mux: RTL and testbench
=====================================

// Module: channel_select_mux
// PURPOSE
//  Parametrised, registered N-channel selector that replaces the 17-bit combinational select mux.
//  Each channel offers a WIDTH-bit word with a valid bit.
//  Channels are picked by explicit Selection (direct mode) or by a round-robin scan (scan mode).
//  The chosen word is captured into an output register with a valid/ready handshake.
//  Sits between multiple producers (ALU, memory, immediate gen) and one consumer (writeback/regfile port).
// PARAMETERS
//  WIDTH     17  data width per channel
//  CHANNELS  16  number of input channels (>=2); SEL_W = $clog2(CHANNELS) is a derived localparam
// PORTS
//  Clock       in   1               rising-edge clock; only clock
//  Reset_n     in   1               asynchronous, active-low reset
//  Input       in   CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
//  InValid     in   CHANNELS        channel c holds a word
//  InAck       out  CHANNELS        one-hot pulse: channel consumed this cycle
//  Selection   in   SEL_W           channel index, direct mode
//  Mode        in   1               0 = direct, 1 = round-robin scan
//  Output      out  WIDTH           registered selected word
//  OutChannel  out  SEL_W           index of channel held in Output
//  OutValid    out  1               Output holds an unconsumed word
//  OutReady    in   1               consumer accepts Output this cycle
//  SelError    out  1               sticky: direct-mode Selection >= CHANNELS seen
// BEHAVIOUR
//  - Reset values: Output=0, OutChannel=0, OutValid=0, InAck=0, SelError=0, scan pointer=0.
//  - Reset applies immediately mid-transfer; the captured word is discarded.
//  - load = !OutValid | OutReady. A capture happens when load=1 and a candidate exists.
//  - Capture effects, same edge:
//      Output <= Input[cand], OutChannel <= cand, OutValid <= 1, InAck[cand]=1 that cycle (combinational from load&cand).
//  - No capture while load=1: OutValid <= 0.
//  - load=0: all registers hold; InAck=0.
//  - Latency is 1 cycle from channel valid to OutValid. Full throughput is 1 word/cycle when OutReady is held at 1.
//  - Direct mode candidate: Selection, provided Selection < CHANNELS and InValid[Selection]=1.
//  - Direct mode with Selection >= CHANNELS: no capture; SelError <= 1. It clears only on reset.
//  - Scan mode candidate: first c with InValid[c]=1, searching ptr, ptr+1, ... wrapping modulo CHANNELS.
//      On capture, ptr <= (cand+1) mod CHANNELS; with CHANNELS not a power of 2, wrap from CHANNELS-1 to 0.
//      No valid channels: no capture; ptr holds.
//  - Mode is sampled every cycle. On a 0->1 change ptr is unchanged; the scan resumes from the stored ptr.
//  - Simultaneous OutReady=1 and a new candidate: the old word retires and the new word loads on the same edge (no bubble).
//  - Input/InValid are not registered; producers must hold data until InAck.
// CONFIGURATION
//  CHANNEL_MASK_EN defined:
//    - Adds input port ChannelMask [CHANNELS-1:0].
//    - Effective valid = InValid & ~ChannelMask in both modes.
//    - A masked Selection in direct mode gives no capture and does not set SelError.
//  CHANNEL_MASK_EN undefined: the port is absent; effective valid = InValid.
// STRUCTURE
//  - Package selmux_pkg:
//      MODE_DIRECT=1'b0, MODE_SCAN=1'b1 constants
//      function clog2 for SEL_W
//      default WIDTH/CHANNELS constants shared with the CPU top.
//  - Sub-module rr_pick: combinational round-robin priority picker.
//      Inputs: req[CHANNELS], ptr[SEL_W]. Outputs: gnt_idx[SEL_W], gnt_any.
//      Top level holds all registers and the handshake.
// TESTING (WIDTH=17, CHANNELS=16 unless noted)
//  1. Reset_n=0 mid-run with OutValid=1 -> Output=0, OutValid=0, SelError=0 immediately (async), before the next edge.
//  2. Direct mode: ch c = 42+c, all valid, OutReady=1, Selection swept 0..10 one per cycle
//     -> each next cycle Output=42+Selection, OutChannel=Selection, InAck one-hot.
//  3. Backpressure: OutReady=0 for 3 cycles after capture of ch5=47
//     -> Output holds 47, InAck=0. Ready rises -> next word loads on the same edge.
//  4. Scan mode: InValid=16'h8011, OutReady=1
//     -> grants 0,4,15,0,4,...; with only ch15 valid, ptr wraps to 0.
//  5. CHANNELS=10, direct Selection=12 -> no capture, SelError=1 and sticky after Selection returns to 3.
//  6. CHANNEL_MASK_EN: mask=16'h0010, InValid=16'h0011, scan mode -> only ch0 granted; ch4 never acked.

Source files
------------

// File: rtl/selmux_pkg.sv
// Shared definitions for the channel select mux: mode encodings, default geometry, clog2 helper.
// Default WIDTH/CHANNELS match the CPU top so every instance agrees on bus geometry.
package selmux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEF_WIDTH    = 17;
  localparam int DEF_CHANNELS = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/channel_select_mux_if.sv
// Channel bundle between producers, the select mux and its consumer; master = producers/consumer side.
// ChannelMask exists only when CHANNEL_MASK_EN is defined.
interface channel_select_mux_if
  import selmux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int SEL_W = clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] Input;
  logic [CHANNELS-1:0]       InValid;
  logic [CHANNELS-1:0]       InAck;
  logic [SEL_W-1:0]          Selection;
  logic                      Mode;
  logic [WIDTH-1:0]          Output;
  logic [SEL_W-1:0]          OutChannel;
  logic                      OutValid;
  logic                      OutReady;
  logic                      SelError;
`ifdef CHANNEL_MASK_EN
  logic [CHANNELS-1:0]       ChannelMask;
`endif

  modport master (
    output Input, InValid, Selection, Mode, OutReady,
`ifdef CHANNEL_MASK_EN
    output ChannelMask,
`endif
    input  InAck, Output, OutChannel, OutValid, SelError
  );

  modport slave (
    input  Input, InValid, Selection, Mode, OutReady,
`ifdef CHANNEL_MASK_EN
    input  ChannelMask,
`endif
    output InAck, Output, OutChannel, OutValid, SelError
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at ptr, ptr+1, ... wrapping at CHANNELS.
// Zero latency; ptr must already be below CHANNELS.
module rr_pick
  import selmux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                gnt_any
);

  function automatic logic [SEL_W-1:0] idx_at(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  // Walk from the farthest offset down so the nearest requester overwrites and wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = CHANNELS - 1; off >= 0; off--) begin
      if (req[idx_at(ptr, off)]) begin
        gnt_idx = idx_at(ptr, off);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_select_mux.sv
// Registered N-channel selector (direct or round-robin scan), 1-cycle latency, 1 word/cycle; output holds under OutReady=0.
// CHANNEL_MASK_EN adds ChannelMask, which removes channels from both direct and scan selection.
module channel_select_mux
  import selmux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input logic                 Clock,
  input logic                 Reset_n,
  channel_select_mux_if.slave bus
);

  localparam int SEL_W = clog2(CHANNELS);
  localparam int PAD_N = 1 << SEL_W;

  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_vld_q, out_vld_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [CHANNELS-1:0] eff_vld;
  logic [PAD_N-1:0]    eff_vld_pad;
  logic [WIDTH-1:0]    words [PAD_N];
  logic                scan_mode;
  logic                load;
  logic                sel_in_range;
  logic                direct_hit;
  logic [SEL_W-1:0]    scan_idx;
  logic                scan_any;
  logic [SEL_W-1:0]    cand;
  logic                cand_vld;

`ifdef CHANNEL_MASK_EN
  assign eff_vld = bus.InValid & ~bus.ChannelMask;
`else
  assign eff_vld = bus.InValid;
`endif

  // Pad to a power of two so an out-of-range Selection indexes a defined zero.
  assign eff_vld_pad = PAD_N'(eff_vld);

  for (genvar c = 0; c < PAD_N; c++) begin : g_word
    if (c < CHANNELS) begin : g_real
      assign words[c] = bus.Input[c*WIDTH +: WIDTH];
    end else begin : g_pad
      assign words[c] = '0;
    end
  end

  assign scan_mode    = (bus.Mode == MODE_SCAN);
  assign load         = !out_vld_q || bus.OutReady;
  assign sel_in_range = ({1'b0, bus.Selection} < (SEL_W + 1)'(CHANNELS));
  assign direct_hit   = sel_in_range && eff_vld_pad[bus.Selection];

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .req     (eff_vld),
    .ptr     (ptr_q),
    .gnt_idx (scan_idx),
    .gnt_any (scan_any)
  );

  assign cand     = scan_mode ? scan_idx : bus.Selection;
  assign cand_vld = scan_mode ? scan_any : direct_hit;

  assign bus.InAck = (Reset_n && load && cand_vld) ? (CHANNELS'(1) << cand) : '0;

  always_comb begin
    out_dat_d = out_dat_q;
    out_ch_d  = out_ch_q;
    out_vld_d = out_vld_q;
    sel_err_d = sel_err_q;
    ptr_d     = ptr_q;
    if (load) begin
      if (cand_vld) begin
        out_dat_d = words[cand];
        out_ch_d  = cand;
        out_vld_d = 1'b1;
        if (scan_mode) ptr_d = (cand == SEL_W'(CHANNELS - 1)) ? '0 : cand + 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
      if (!scan_mode && !sel_in_range) sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_dat_q <= '0;
      out_ch_q  <= '0;
      out_vld_q <= 1'b0;
      sel_err_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      out_dat_q <= out_dat_d;
      out_ch_q  <= out_ch_d;
      out_vld_q <= out_vld_d;
      sel_err_q <= sel_err_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.Output     = out_dat_q;
  assign bus.OutChannel = out_ch_q;
  assign bus.OutValid   = out_vld_q;
  assign bus.SelError   = sel_err_q;

endmodule

// File: tb/tb_channel_select_mux.sv
// Scoreboard bench for channel_select_mux: reference model predicts captures, a negedge monitor retires them.
// A second 10-channel instance covers the out-of-range Selection error path.
`timescale 1ns/1ps
module tb_channel_select_mux;
  import selmux_pkg::*;

  localparam int W    = 17;
  localparam int CH   = 16;
  localparam int CH10 = 10;

  typedef struct {
    logic [W-1:0] dat;
    int           ch;
  } item_t;

  logic Clock;
  logic Reset_n;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  channel_select_mux_if #(.WIDTH(W), .CHANNELS(CH))   bus ();
  channel_select_mux_if #(.WIDTH(W), .CHANNELS(CH10)) bus10 ();

  channel_select_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  channel_select_mux #(.WIDTH(W), .CHANNELS(CH10)) dut10 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus10)
  );

  int    n_cmp;
  int    n_err;
  item_t sb_q[$];
  item_t mon_item;
  bit    mon_en;

  bit    m_vld, m_err;
  int    m_ptr;
  bit    p_push, p_vld, p_err;
  int    p_ptr;
  item_t p_item;

  logic [CH-1:0]     cur_mask;
  logic [CH-1:0]     ack;
  logic [CH*W-1:0]   d42;
  logic [CH*W-1:0]   rd;
  logic [CH-1:0]     rv;
  logic [CH10*W-1:0] d10;
  int                exp_scan [6];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference selection rule: direct index if legal and valid, else nearest valid from ptr.
  function automatic int model_pick(input logic [CH-1:0] v, input int sel, input bit scan, input int ptr);
    if (!scan) return (sel < CH && v[sel]) ? sel : -1;
    for (int i = 0; i < CH; i++) begin
      if (v[(ptr + i) % CH]) return (ptr + i) % CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_vld = 0; m_err = 0; m_ptr = 0;
    p_push = 0; p_vld = 0; p_err = 0; p_ptr = 0;
  endtask

  task automatic bus_idle();
    bus.Input = '0; bus.InValid = '0; bus.Selection = '0; bus.Mode = 1'b0; bus.OutReady = 1'b1;
`ifdef CHANNEL_MASK_EN
    bus.ChannelMask = '0;
`endif
  endtask

  task automatic cycle(input logic [CH*W-1:0] d, input logic [CH-1:0] v, input int sel,
                       input bit scan, input bit rdy, output logic [CH-1:0] obs_ack);
    int            c;
    bit            ld;
    logic [CH-1:0] exp_ack;
    @(posedge Clock);
    #1;
    if (p_push) sb_q.push_back(p_item);
    p_push = 0;
    m_vld = p_vld; m_ptr = p_ptr; m_err = p_err;
    #1;
    bus.Input = d; bus.InValid = v; bus.Selection = 4'(sel); bus.Mode = scan; bus.OutReady = rdy;
`ifdef CHANNEL_MASK_EN
    bus.ChannelMask = cur_mask;
`endif
    #1;
    ld = !m_vld || rdy;
    c = model_pick(v & ~cur_mask, sel, scan, m_ptr);
    exp_ack = (ld && c >= 0) ? (CH'(1) << c) : '0;
    obs_ack = bus.InAck;
    chk("in_ack", obs_ack, exp_ack);
    p_vld = m_vld; p_ptr = m_ptr; p_err = m_err;
    if (ld && c >= 0) begin
      p_push = 1;
      p_item.dat = d[c*W +: W];
      p_item.ch = c;
      p_vld = 1;
      if (scan) p_ptr = (c + 1) % CH;
    end else if (ld) begin
      p_vld = 0;
    end
    if (ld && !scan && sel >= CH) p_err = 1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; mon_en = 0; cur_mask = '0;
    exp_scan = '{0, 4, 15, 0, 4, 15};
    for (int c = 0; c < CH; c++) d42[c*W +: W] = W'(42 + c);
    for (int c = 0; c < CH10; c++) d10[c*W +: W] = W'(42 + c);
    bus_idle();
    bus10.Input = '0; bus10.InValid = '0; bus10.Selection = '0; bus10.Mode = 1'b0; bus10.OutReady = 1'b1;
`ifdef CHANNEL_MASK_EN
    bus10.ChannelMask = '0;
`endif
    model_reset();

    fork
      forever begin
        @(negedge Clock);
        if (mon_en) begin
          chk("out_vld", bus.OutValid, sb_q.size() != 0);
          chk("sel_err", bus.SelError, m_err);
          if (bus.OutValid && bus.OutReady && sb_q.size() != 0) begin
            mon_item = sb_q.pop_front();
            chk("out_dat", bus.Output, mon_item.dat);
            chk("out_ch", bus.OutChannel, mon_item.ch);
          end
        end
      end
    join_none

    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_out", bus.Output, 0);
    chk("rst_vld", bus.OutValid, 0);
    chk("rst_ch", bus.OutChannel, 0);
    chk("rst_ack", bus.InAck, 0);
    chk("rst_err", bus.SelError, 0);
    chk("rst_err10", bus10.SelError, 0);
    @(posedge Clock);
    @(posedge Clock);
    #3 Reset_n = 1'b1;
    mon_en = 1;

    // Direct sweep with every channel valid.
    for (int s = 0; s <= 10; s++) begin
      cycle(d42, '1, s, 0, 1, ack);
      chk("dir_ack", ack, CH'(1) << s);
    end
    cycle('0, '0, 0, 0, 1, ack);
    cycle('0, '0, 0, 0, 1, ack);

    // Backpressure: hold ch5 for three cycles, then retire and load ch6 on one edge.
    cycle(d42, '1, 5, 0, 0, ack);
    chk("bp_cap_ack", ack, CH'(1) << 5);
    for (int i = 0; i < 3; i++) begin
      cycle(d42, '1, 5, 0, 0, ack);
      chk("bp_hold_ack", ack, 0);
      chk("bp_hold_dat", bus.Output, 47);
    end
    cycle(d42, '1, 6, 0, 1, ack);
    chk("bp_swap_ack", ack, CH'(1) << 6);
    cycle('0, '0, 0, 0, 1, ack);
    chk("bp_swap_dat", bus.Output, 48);
    chk("bp_swap_vld", bus.OutValid, 1);
    cycle('0, '0, 0, 0, 1, ack);

    // Scan over channels 0, 4, 15 starting from pointer 0.
    for (int i = 0; i < 6; i++) begin
      cycle(d42, 16'h8011, 0, 1, 1, ack);
      chk("scan_grant", ack, CH'(1) << exp_scan[i]);
    end
    cycle(d42, 16'h8000, 0, 1, 1, ack);
    chk("scan_only15", ack, 16'h8000);
    cycle(d42, 16'h0011, 0, 1, 1, ack);
    chk("scan_wrap0", ack, 16'h0001);
    cycle('0, '0, 0, 0, 1, ack);
    cycle('0, '0, 0, 0, 1, ack);

`ifdef CHANNEL_MASK_EN
    cur_mask = 16'h0010;
    for (int i = 0; i < 6; i++) begin
      cycle(d42, 16'h0011, 0, 1, 1, ack);
      chk("mask_grant", ack, 16'h0001);
    end
    cycle(d42, 16'h0010, 4, 0, 1, ack);
    chk("mask_direct", ack, 0);
    cur_mask = '0;
    cycle('0, '0, 0, 0, 1, ack);
    cycle('0, '0, 0, 0, 1, ack);
`endif

    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < CH; c++) rd[c*W +: W] = W'($urandom);
      rv = CH'($urandom) & (($urandom_range(0, 1) != 0) ? CH'($urandom) : '1);
`ifdef CHANNEL_MASK_EN
      cur_mask = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
`endif
      cycle(rd, rv, int'($urandom_range(0, CH - 1)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0, ack);
    end
    cur_mask = '0;
    cycle('0, '0, 0, 0, 1, ack);
    cycle('0, '0, 0, 0, 1, ack);

    // Asynchronous reset while a word is held.
    cycle(d42, '1, 3, 0, 0, ack);
    cycle(d42, '1, 3, 0, 0, ack);
    mon_en = 0;
    @(negedge Clock);
    chk("pre_rst_vld", bus.OutValid, 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("mid_rst_out", bus.Output, 0);
    chk("mid_rst_vld", bus.OutValid, 0);
    chk("mid_rst_err", bus.SelError, 0);
    chk("mid_rst_ack", bus.InAck, 0);
    bus_idle();
    model_reset();
    @(posedge Clock);
    #3 Reset_n = 1'b1;
    mon_en = 1;
    cycle('0, '0, 0, 0, 1, ack);

    // Ten-channel instance: illegal Selection sets a sticky error.
    @(posedge Clock);
    #2;
    bus10.Input = d10; bus10.InValid = '1; bus10.Mode = 1'b0; bus10.OutReady = 1'b1;
    bus10.Selection = 4'd12;
    #1 chk("c10_ack_oor", bus10.InAck, 0);
    @(posedge Clock);
    #3;
    chk("c10_vld_oor", bus10.OutValid, 0);
    chk("c10_err_set", bus10.SelError, 1);
    bus10.Selection = 4'd3;
    #1 chk("c10_ack3", bus10.InAck, 10'h008);
    @(posedge Clock);
    #3;
    chk("c10_dat3", bus10.Output, 45);
    chk("c10_ch3", bus10.OutChannel, 3);
    chk("c10_vld3", bus10.OutValid, 1);
    chk("c10_err_sticky", bus10.SelError, 1);
    @(posedge Clock);
    #3;
    chk("c10_err_sticky2", bus10.SelError, 1);
    bus10.InValid = '0;

    cycle('0, '0, 0, 0, 1, ack);
    cycle('0, '0, 0, 0, 1, ack);
    @(negedge Clock);
    #1;
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
